// File: rtl/gb_bg_fetcher.sv
// Background tile fetcher: walks one scanline's worth of tile-map entries,
// reads the two bitplanes for each tile, and hands each row to the pixel FIFO.
module gb_bg_fetcher #(
    parameter int TILES = 21
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [7:0]  ly,
    input  logic [7:0]  scx,
    input  logic [7:0]  scy,
    input  logic        map_sel,
    input  logic        data_sel,
    output logic [12:0] vadr,
    output logic        vread,
    input  logic [7:0]  vdata,
    output logic [7:0]  pix_lo,
    output logic [7:0]  pix_hi,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, MAP_A, MAP_D, LO_A, LO_D, HI_A, HI_D, PUSH
    } state_t;

    localparam logic [5:0] LAST = 6'(TILES - 1);

    state_t      state, state_nx;
    logic [7:0]  line_y;
    logic [4:0]  tile_x;
    logic [5:0]  cnt;
    logic [7:0]  tile;
    logic [7:0]  lo_q;
    logic [7:0]  hi_q;
    logic [12:0] vadr_q;
    logic        unused_scx;

    // Fine scroll bits are consumed downstream (pixel discard), not here.
    assign unused_scx = ^scx[2:0];

    assign pix_lo = lo_q;
    assign pix_hi = hi_q;

    // Next-state and output decode; address is formed live in *_A states
    // so map_sel/data_sel are sampled there, and held from vadr_q otherwise.
    always_comb begin
        state_nx  = state;
        vadr      = vadr_q;
        vread     = 1'b0;
        pix_valid = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (start) state_nx = MAP_A;
            MAP_A: begin
                vread    = 1'b1;
                vadr     = {2'b11, map_sel, line_y[7:3], tile_x};
                state_nx = MAP_D;
            end
            MAP_D: state_nx = LO_A;
            LO_A: begin
                vread    = 1'b1;
                vadr     = {~data_sel & ~tile[7], tile, line_y[2:0], 1'b0};
                state_nx = LO_D;
            end
            LO_D:  state_nx = HI_A;
            HI_A: begin
                vread    = 1'b1;
                vadr     = {~data_sel & ~tile[7], tile, line_y[2:0], 1'b1};
                state_nx = HI_D;
            end
            HI_D:  state_nx = PUSH;
            PUSH: begin
                pix_valid = 1'b1;
                if (pix_ready) begin
                    if (cnt == LAST) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = MAP_A;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register plus line/tile bookkeeping and VRAM data capture.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= IDLE;
            vadr_q <= '0;
            line_y <= '0;
            tile_x <= '0;
            cnt    <= '0;
            tile   <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
        end else begin
            state  <= state_nx;
            vadr_q <= vadr;
            case (state)
                IDLE: if (start) begin
                    line_y <= scy + ly;
                    tile_x <= scx[7:3];
                    cnt    <= '0;
                end
                MAP_D: tile <= vdata;
                LO_D:  lo_q <= vdata;
                HI_D:  hi_q <= vdata;
                PUSH: if (pix_ready) begin
                    tile_x <= tile_x + 5'd1;
                    cnt    <= cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
